// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with registered occupancy/threshold flags
// and sticky overflow/underflow indicators.
//
// Build option: define FIFO_FWFT_EN for first-word-fall-through reads
// (head word presented on rd_data_o while not empty). Without it, reads are
// registered: rd_data_o updates and rd_valid_o pulses one cycle after an
// accepted read.
//
// Reset rstn_i is synchronous and active-low. Storage is never reset; only
// pointers, count, flags and the read-output register are.
module uart_sync_fifo #(
    parameter  int DATA_WIDTH    = 8,
    parameter  int FIFO_DEPTH    = 16,
    parameter  int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter  int AEMPTY_THRESH = 2,
    localparam int ADDR_WIDTH    = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  clr_i,
    input  logic                  wren_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rden_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  afull_o,
    output logic                  aempty_o,
    output logic [ADDR_WIDTH-1:0] count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    // Storage index only needs to span 0..FIFO_DEPTH-1, which is narrower
    // than the pointer/count width when FIFO_DEPTH is a power of two.
    localparam int IDX_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [ADDR_WIDTH-1:0] DEPTH_C    = ADDR_WIDTH'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR_C = ADDR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] AFULL_C    = ADDR_WIDTH'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH-1:0] AEMPTY_C   = ADDR_WIDTH'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH-1:0] ONE_C      = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] count_q;
    logic [ADDR_WIDTH-1:0] count_nxt;
    logic [IDX_WIDTH-1:0]  wr_idx;
    logic [IDX_WIDTH-1:0]  rd_idx;

    logic full_q;
    logic empty_q;
    logic afull_q;
    logic aempty_q;
    logic ovf_q;
    logic udf_q;

    logic wr_acc;
    logic rd_acc;

    // Pointers advance by one and wrap at the last entry; the depth need not
    // be a power of two, so the wrap is explicit.
    function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_PTR_C) ? '0 : p + ONE_C;
    endfunction

    function automatic logic afull_of(input logic [ADDR_WIDTH-1:0] c);
        return c >= AFULL_C;
    endfunction

    function automatic logic aempty_of(input logic [ADDR_WIDTH-1:0] c);
        return c <= AEMPTY_C;
    endfunction

    // Acceptance is decided from the registered flags, so a write at full is
    // refused even when a read frees a slot in the same cycle, and a read at
    // empty is refused even when a write arrives in the same cycle.
    assign wr_acc = wren_i & ~full_q;
    assign rd_acc = rden_i & ~empty_q;

    assign wr_idx = wr_ptr[IDX_WIDTH-1:0];
    assign rd_idx = rd_ptr[IDX_WIDTH-1:0];

    // Occupancy after this edge: +1 write only, -1 read only, else unchanged.
    always_comb begin
        count_nxt = count_q;
        if (wr_acc && !rd_acc) begin
            count_nxt = count_q + ONE_C;
        end else if (!wr_acc && rd_acc) begin
            count_nxt = count_q - ONE_C;
        end
    end

    // Control state: pointers, count, registered flags and sticky errors.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else if (clr_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= afull_of('0);
            aempty_q <= aempty_of('0);
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count_q  <= count_nxt;
            full_q   <= (count_nxt == DEPTH_C);
            empty_q  <= (count_nxt == '0);
            afull_q  <= afull_of(count_nxt);
            aempty_q <= aempty_of(count_nxt);
            if (wren_i && full_q) begin
                ovf_q <= 1'b1;
            end
            if (rden_i && empty_q) begin
                udf_q <= 1'b1;
            end
        end
    end

    // Storage write; contents survive reset and flush by design.
    always_ff @(posedge clk_i) begin
        if (rstn_i && !clr_i && wr_acc) begin
            mem[wr_idx] <= wr_data_i;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is visible whenever the FIFO holds data; zero when empty so
    // the output is clean straight after reset.
    assign rd_data_o  = empty_q ? '0 : mem[rd_idx];
    assign rd_valid_o = ~empty_q;
`else
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    // Registered read port: data captured on an accepted read, held otherwise.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (clr_i) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= mem[rd_idx];
            end
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
`endif

    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign afull_o     = afull_q;
    assign aempty_o    = aempty_q;
    assign count_o     = count_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = udf_q;

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Self-checking bench for uart_sync_fifo (FIFO_DEPTH=5). A queue scoreboard
// holds the words expected out of the FIFO; a stimulus table with
// hand-derived counts and error flags drives the main sequences, followed by
// hand-written multi-cycle corner cases.
module tb_uart_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 5;
    localparam int AW    = $clog2(DEPTH + 1);
    localparam int AFT   = DEPTH - 2;
    localparam int AET   = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          clr = 1'b0;
    logic          wren = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          rden = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full, empty, afull, aempty;
    logic [AW-1:0] count;
    logic          ovf, udf;

    uart_sync_fifo #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .clr_i       (clr),
        .wren_i      (wren),
        .wr_data_i   (wdata),
        .rden_i      (rden),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .full_o      (full),
        .empty_o     (empty),
        .afull_o     (afull),
        .aempty_o    (aempty),
        .count_o     (count),
        .overflow_o  (ovf),
        .underflow_o (udf)
    );

    always #5 clk = ~clk;

    // Scoreboard / reference state
    logic [DW-1:0] sb_q[$];
    bit            m_ovf, m_udf, m_vld;
    logic [DW-1:0] m_data;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          clr;
        bit          wr;
        logic [7:0]  wd;
        bit          rd;
        int          cnt;
        bit          ovf;
        bit          udf;
    } vec_t;

    vec_t tbl[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare every DUT output against the reference state.
    task automatic check_all(input string tag);
        int c;
        c = sb_q.size();
        check({tag, ".count"},  32'(count), 32'(c));
        check({tag, ".full"},   32'(full), 32'(c == DEPTH));
        check({tag, ".empty"},  32'(empty), 32'(c == 0));
        check({tag, ".afull"},  32'(afull), 32'(c >= AFT));
        check({tag, ".aempty"}, 32'(aempty), 32'(c <= AET));
        check({tag, ".ovf"},    32'(ovf), 32'(m_ovf));
        check({tag, ".udf"},    32'(udf), 32'(m_udf));
`ifdef FIFO_FWFT_EN
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'(c != 0));
        check({tag, ".rd_data"},  32'(rd_data), (c != 0) ? 32'(sb_q[0]) : 32'd0);
`else
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_vld));
        check({tag, ".rd_data"},  32'(rd_data), 32'(m_data));
`endif
    endtask

    // One clock of stimulus; reference updated for the same edge.
    task automatic step(input bit c, input bit w, input logic [7:0] d, input bit r, input string tag);
        bit wa, ra;
        @(negedge clk);
        clr = c; wren = w; wdata = d; rden = r;
        if (c) begin
            sb_q.delete();
            m_vld = 0; m_ovf = 0; m_udf = 0;
        end else begin
            wa = w && (sb_q.size() < DEPTH);
            ra = r && (sb_q.size() > 0);
            if (w && !wa) m_ovf = 1;
            if (r && !ra) m_udf = 1;
            m_vld = ra;
            if (ra) m_data = sb_q.pop_front();
            if (wa) sb_q.push_back(d);
        end
        @(posedge clk);
        #1;
        clr = 0; wren = 0; rden = 0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rstn = 0; clr = 0; wren = 0; rden = 0;
        sb_q.delete();
        m_vld = 0; m_ovf = 0; m_udf = 0; m_data = '0;
        @(posedge clk);
        #1;
        check_all(tag);
        check({tag, ".rst_data"}, 32'(rd_data), 32'd0);
        rstn = 1;
    endtask

    initial begin
        // clr wr  data   rd  cnt ovf udf
        tbl[0]  = '{0, 1, 8'h11, 0, 1, 0, 0};
        tbl[1]  = '{0, 1, 8'h22, 0, 2, 0, 0};
        tbl[2]  = '{0, 1, 8'h33, 0, 3, 0, 0};
        tbl[3]  = '{0, 0, 8'h00, 1, 2, 0, 0};
        tbl[4]  = '{0, 0, 8'h00, 1, 1, 0, 0};
        tbl[5]  = '{0, 0, 8'h00, 1, 0, 0, 0};
        tbl[6]  = '{0, 0, 8'h00, 1, 0, 0, 1};  // read while empty
        tbl[7]  = '{1, 0, 8'h00, 0, 0, 0, 0};  // clr drops underflow
        tbl[8]  = '{0, 1, 8'h40, 0, 1, 0, 0};
        tbl[9]  = '{0, 1, 8'h41, 0, 2, 0, 0};
        tbl[10] = '{0, 1, 8'h42, 0, 3, 0, 0};
        tbl[11] = '{0, 1, 8'h43, 0, 4, 0, 0};
        tbl[12] = '{0, 1, 8'h44, 0, 5, 0, 0};
        tbl[13] = '{0, 1, 8'h99, 0, 5, 1, 0};  // write while full
        tbl[14] = '{0, 1, 8'h98, 1, 4, 1, 0};  // wr+rd at full: read wins
        tbl[15] = '{1, 1, 8'h97, 1, 0, 0, 0};  // clr beats wr/rd
        tbl[16] = '{0, 1, 8'h55, 1, 1, 0, 1};  // wr+rd at empty: write wins
        tbl[17] = '{1, 0, 8'h00, 0, 0, 0, 0};

        do_reset("reset0");

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].clr, tbl[i].wr, tbl[i].wd, tbl[i].rd, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.cnt_const", i), 32'(count), 32'(tbl[i].cnt));
            check($sformatf("tbl%0d.ovf_const", i), 32'(ovf), 32'(tbl[i].ovf));
            check($sformatf("tbl%0d.udf_const", i), 32'(udf), 32'(tbl[i].udf));
        end

        // Steady-state streaming at count 2; depth 5 forces several wraps.
        do_reset("reset1");
        step(0, 1, 8'hA0, 0, "stream_fill0");
        step(0, 1, 8'hA1, 0, "stream_fill1");
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 8'(8'hB0 + i), 1, $sformatf("stream%0d", i));
            check($sformatf("stream%0d.cnt2", i), 32'(count), 32'd2);
        end
        step(0, 0, 8'h00, 1, "stream_drain0");
        step(0, 0, 8'h00, 1, "stream_drain1");
        check("stream.empty_end", 32'(empty), 32'd1);

        // Reset mid-transfer discards stored words.
        do_reset("reset2");
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'(8'hC0 + i), 0, $sformatf("fill4_%0d", i));
        end
        check("fill4.cnt", 32'(count), 32'd4);
        do_reset("mid_reset");
        check("mid_reset.cnt0", 32'(count), 32'd0);
        check("mid_reset.empty", 32'(empty), 32'd1);
        step(0, 0, 8'h00, 1, "post_reset_read");
        check("post_reset_read.udf", 32'(udf), 32'd1);

`ifdef FIFO_FWFT_EN
        // Fall-through: a word written into an empty FIFO shows without rden.
        do_reset("reset3");
        step(0, 1, 8'hA5, 0, "fwft_write");
        check("fwft.data", 32'(rd_data), 32'hA5);
        check("fwft.valid", 32'(rd_valid), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
